// File: rtl/fc2_layer_sequencer.sv
// fc2_layer_sequencer: walks the FC-2 weight ROM, accumulates 5 neuron sums, adds bias, shifts and saturates.
// Optional macro FC2_ARGMAX_EN adds the registered Class_out argmax port.
module fc2_layer_sequencer #(
    parameter int Bit_width = 16,
    parameter int IN_LEN    = 4,
    parameter int FRAC_BITS = 8,
    parameter int ACC_W     = 40
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        Start,
    output logic                        Busy,
    output logic                        Done,
    output logic                        Rom_enable,
    output logic [3:0]                  Rom_width,
    input  logic signed [Bit_width-1:0] Rom_data_0,
    input  logic signed [Bit_width-1:0] Rom_data_1,
    input  logic signed [Bit_width-1:0] Rom_data_2,
    input  logic signed [Bit_width-1:0] Rom_data_3,
    input  logic signed [Bit_width-1:0] Rom_data_4,
    input  logic signed [Bit_width-1:0] Rom_data_5,
    output logic [3:0]                  Act_idx,
    input  logic signed [Bit_width-1:0] Act_in,
    output logic signed [Bit_width-1:0] Result_0,
    output logic signed [Bit_width-1:0] Result_1,
    output logic signed [Bit_width-1:0] Result_2,
    output logic signed [Bit_width-1:0] Result_3,
    output logic signed [Bit_width-1:0] Result_4
`ifdef FC2_ARGMAX_EN
    ,
    output logic [2:0]                  Class_out
`endif
);
    localparam int PW = 2 * Bit_width;
    localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(2 ** (Bit_width - 1) - 1);
    localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(-(2 ** (Bit_width - 1)));

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, OUT} state_t;

    state_t                      state;
    logic [3:0]                  idx;
    logic signed [ACC_W-1:0]     acc [5];
    logic signed [Bit_width-1:0] res [5];
    logic signed [Bit_width-1:0] wt [5];
    logic signed [PW-1:0]        prod [5];
    logic signed [ACC_W-1:0]     prod_x [5];
    logic signed [ACC_W-1:0]     shifted [5];
    logic signed [Bit_width-1:0] sat [5];
    logic signed [ACC_W-1:0]     bias_x;

    assign wt[0] = Rom_data_1;
    assign wt[1] = Rom_data_2;
    assign wt[2] = Rom_data_3;
    assign wt[3] = Rom_data_4;
    assign wt[4] = Rom_data_5;

    assign Result_0 = res[0];
    assign Result_1 = res[1];
    assign Result_2 = res[2];
    assign Result_3 = res[3];
    assign Result_4 = res[4];

    always_comb begin
        bias_x = ACC_W'(Rom_data_0) <<< FRAC_BITS;
        for (int n = 0; n < 5; n++) begin
            prod[n]    = Act_in * wt[n];
            prod_x[n]  = ACC_W'(prod[n]);
            shifted[n] = acc[n] >>> FRAC_BITS;
            sat[n]     = shifted[n] > SAT_HI ? Bit_width'(SAT_HI) :
                         shifted[n] < SAT_LO ? Bit_width'(SAT_LO) : shifted[n][Bit_width-1:0];
        end
    end

`ifdef FC2_ARGMAX_EN
    logic [2:0]                  best;
    logic signed [Bit_width-1:0] best_v;

    // strict compare keeps the lowest index on ties
    always_comb begin
        best   = 3'd0;
        best_v = sat[0];
        for (int n = 1; n < 5; n++) begin
            if (sat[n] > best_v) begin
                best   = 3'(n);
                best_v = sat[n];
            end
        end
    end
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            idx        <= 4'd0;
            Busy       <= 1'b0;
            Done       <= 1'b0;
            Rom_enable <= 1'b0;
            Rom_width  <= 4'd0;
            Act_idx    <= 4'd0;
            for (int n = 0; n < 5; n++) begin
                acc[n] <= '0;
                res[n] <= '0;
            end
`ifdef FC2_ARGMAX_EN
            Class_out  <= 3'd0;
`endif
        end else begin
            Done <= 1'b0;
            case (state)
                IDLE: begin
                    if (Start) begin
                        for (int n = 0; n < 5; n++) acc[n] <= '0;
                        idx   <= 4'd0;
                        Busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    Rom_enable <= 1'b1;
                    Rom_width  <= idx;
                    Act_idx    <= idx;
                    // data for the index issued on the previous edge arrives now; none on the first edge
                    if (idx != 4'd0)
                        for (int n = 0; n < 5; n++) acc[n] <= acc[n] + prod_x[n];
                    if (idx == 4'(IN_LEN - 1))
                        state <= DRAIN;
                    else
                        idx <= idx + 4'd1;
                end
                DRAIN: begin
                    for (int n = 0; n < 5; n++) acc[n] <= acc[n] + prod_x[n] + bias_x;
                    state <= OUT;
                end
                OUT: begin
                    Rom_enable <= 1'b0;
                    for (int n = 0; n < 5; n++) res[n] <= sat[n];
`ifdef FC2_ARGMAX_EN
                    Class_out  <= best;
`endif
                    Done  <= 1'b1;
                    Busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fc2_layer_sequencer.sv
// tb_fc2_layer_sequencer: directed checks of fc2_layer_sequencer with a falling-edge ROM/activation model.
module tb_fc2_layer_sequencer;
    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic Start = 1'b0;
    logic Busy, Done, Rom_enable;
    logic [3:0] Rom_width, Act_idx;
    logic signed [15:0] Rom_data_0 = '0, Rom_data_1 = '0, Rom_data_2 = '0;
    logic signed [15:0] Rom_data_3 = '0, Rom_data_4 = '0, Rom_data_5 = '0;
    logic signed [15:0] Act_in = '0;
    logic signed [15:0] Result_0, Result_1, Result_2, Result_3, Result_4;
`ifdef FC2_ARGMAX_EN
    logic [2:0] Class_out;
`endif

    logic signed [15:0] wt [16][5];
    logic signed [15:0] act [16];
    logic signed [15:0] bias;
    logic signed [15:0] res [5];

    int n_checks = 0;
    int n_fail = 0;

    int exp_prod [5] = '{-676, 133, 119, 661, -1090};
    int exp_mix  [5] = '{-508, 111, -21, 510, -690};

    always #5 CLK = ~CLK;

    fc2_layer_sequencer dut (
        .CLK(CLK), .RST(RST), .Start(Start), .Busy(Busy), .Done(Done),
        .Rom_enable(Rom_enable), .Rom_width(Rom_width),
        .Rom_data_0(Rom_data_0), .Rom_data_1(Rom_data_1), .Rom_data_2(Rom_data_2),
        .Rom_data_3(Rom_data_3), .Rom_data_4(Rom_data_4), .Rom_data_5(Rom_data_5),
        .Act_idx(Act_idx), .Act_in(Act_in),
        .Result_0(Result_0), .Result_1(Result_1), .Result_2(Result_2),
        .Result_3(Result_3), .Result_4(Result_4)
`ifdef FC2_ARGMAX_EN
        , .Class_out(Class_out)
`endif
    );

    assign res[0] = Result_0;
    assign res[1] = Result_1;
    assign res[2] = Result_2;
    assign res[3] = Result_3;
    assign res[4] = Result_4;

    // ROM and activation buffer both sample on the falling edge
    always @(negedge CLK) begin
        if (Rom_enable) begin
            Rom_data_0 = bias;
            Rom_data_1 = wt[Rom_width][0];
            Rom_data_2 = wt[Rom_width][1];
            Rom_data_3 = wt[Rom_width][2];
            Rom_data_4 = wt[Rom_width][3];
            Rom_data_5 = wt[Rom_width][4];
        end
        Act_in = act[Act_idx];
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_image();
        for (int i = 0; i < 16; i++) begin
            for (int n = 0; n < 5; n++) wt[i][n] = 16'sd0;
            act[i] = 16'sd0;
        end
        bias = 16'sd0;
    endtask

    task automatic set_row(input int r, input int a, input int b, input int c, input int d, input int e);
        wt[r][0] = 16'(a);
        wt[r][1] = 16'(b);
        wt[r][2] = 16'(c);
        wt[r][3] = 16'(d);
        wt[r][4] = 16'(e);
    endtask

    task automatic load_prod();
        clear_image();
        set_row(0, -200, 50, 40, 200, -300);
        set_row(1, -150, 30, -10, 150, -300);
        set_row(2, -100, 20, 60, 100, -300);
        set_row(3, -236, 23, 19, 201, -200);
        bias = 16'sd10;
        for (int i = 0; i < 4; i++) act[i] = 16'sd256;
    endtask

    task automatic run_and_wait(output int lat);
        Start = 1'b1;
        @(posedge CLK); #1;
        Start = 1'b0;
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge CLK); #1;
            if (Done) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        RST = 1'b1;
        Start = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        n_checks++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", Busy); end
        n_checks++; if (Done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", Done); end
        n_checks++; if (Rom_enable !== 1'b0) begin n_fail++; $display("FAIL reset_rom_enable: got %b want 0", Rom_enable); end
        n_checks++; if (Rom_width !== 4'd0 || Act_idx !== 4'd0) begin n_fail++; $display("FAIL reset_idx: width %0d act_idx %0d want 0 0", Rom_width, Act_idx); end
        for (int n = 0; n < 5; n++) begin
            n_checks++; if (res[n] !== 16'sd0) begin n_fail++; $display("FAIL reset_result%0d: got %0d want 0", n, res[n]); end
        end
`ifdef FC2_ARGMAX_EN
        n_checks++; if (Class_out !== 3'd0) begin n_fail++; $display("FAIL reset_class: got %0d want 0", Class_out); end
`endif
        Start = 1'b0;
        RST = 1'b0;
        @(posedge CLK); #1;
    endtask

    task automatic test_production();
        int lat;
        load_prod();
        run_and_wait(lat);
        n_checks++; if (lat !== 6) begin n_fail++; $display("FAIL prod_latency: got %0d want 6", lat); end
        for (int n = 0; n < 5; n++) begin
            n_checks++; if (res[n] !== 16'(exp_prod[n])) begin n_fail++; $display("FAIL prod_result%0d: got %0d want %0d", n, res[n], exp_prod[n]); end
        end
`ifdef FC2_ARGMAX_EN
        n_checks++; if (Class_out !== 3'd3) begin n_fail++; $display("FAIL prod_class: got %0d want 3", Class_out); end
`endif
        @(posedge CLK); #1;
        n_checks++; if (Done !== 1'b0) begin n_fail++; $display("FAIL prod_done_pulse: got %b want 0", Done); end
    endtask

    task automatic test_rom_bus();
        int en_cnt = 0, busy_cnt = 0, idx_bad = 0;
        int seq [5] = '{-1, -1, -1, -1, -1};
        int exp_seq [5] = '{0, 1, 2, 3, 3};
        load_prod();
        Start = 1'b1;
        @(posedge CLK); #1;
        Start = 1'b0;
        for (int e = 0; e < 10; e++) begin
            if (Busy) busy_cnt++;
            if (Rom_enable) begin
                if (en_cnt < 5) seq[en_cnt] = int'(Rom_width);
                en_cnt++;
                if (Act_idx !== Rom_width) idx_bad++;
            end
            @(posedge CLK); #1;
        end
        n_checks++; if (en_cnt !== 5) begin n_fail++; $display("FAIL bus_enable_cycles: got %0d want 5", en_cnt); end
        n_checks++; if (busy_cnt !== 6) begin n_fail++; $display("FAIL bus_busy_cycles: got %0d want 6", busy_cnt); end
        n_checks++; if (idx_bad !== 0) begin n_fail++; $display("FAIL bus_act_idx: %0d cycles with Act_idx != Rom_width, want 0", idx_bad); end
        for (int i = 0; i < 5; i++) begin
            n_checks++; if (seq[i] !== exp_seq[i]) begin n_fail++; $display("FAIL bus_width%0d: got %0d want %0d", i, seq[i], exp_seq[i]); end
        end
    endtask

    task automatic test_mixed_act();
        int lat;
        load_prod();
        act[0] = 16'sd256;
        act[1] = 16'sd512;
        act[2] = -16'sd256;
        act[3] = 16'sd128;
        run_and_wait(lat);
        n_checks++; if (lat !== 6) begin n_fail++; $display("FAIL mix_latency: got %0d want 6", lat); end
        for (int n = 0; n < 5; n++) begin
            n_checks++; if (res[n] !== 16'(exp_mix[n])) begin n_fail++; $display("FAIL mix_result%0d: got %0d want %0d", n, res[n], exp_mix[n]); end
        end
`ifdef FC2_ARGMAX_EN
        n_checks++; if (Class_out !== 3'd3) begin n_fail++; $display("FAIL mix_class: got %0d want 3", Class_out); end
`endif
    endtask

    task automatic test_saturation();
        int lat;
        clear_image();
        for (int i = 0; i < 4; i++) begin
            set_row(i, 32767, 32767, 32767, 32767, 32767);
            act[i] = 16'sd32767;
        end
        bias = 16'sd32767;
        run_and_wait(lat);
        for (int n = 0; n < 5; n++) begin
            n_checks++; if (res[n] !== 16'sd32767) begin n_fail++; $display("FAIL sat_hi_result%0d: got %0d want 32767", n, res[n]); end
        end
`ifdef FC2_ARGMAX_EN
        n_checks++; if (Class_out !== 3'd0) begin n_fail++; $display("FAIL sat_hi_class: got %0d want 0", Class_out); end
`endif
        for (int i = 0; i < 4; i++) set_row(i, -32768, -32768, -32768, -32768, -32768);
        bias = 16'(-32768);
        run_and_wait(lat);
        for (int n = 0; n < 5; n++) begin
            n_checks++; if (res[n] !== 16'(-32768)) begin n_fail++; $display("FAIL sat_lo_result%0d: got %0d want -32768", n, res[n]); end
        end
    endtask

    task automatic test_start_ignored();
        int dones = 0, first = -1;
        load_prod();
        Start = 1'b1;
        @(posedge CLK); #1;
        for (int e = 1; e <= 14; e++) begin
            Start = (e == 2 || e == 4);
            @(posedge CLK); #1;
            if (Done) begin
                dones++;
                if (first < 0) first = e;
            end
        end
        Start = 1'b0;
        n_checks++; if (dones !== 1) begin n_fail++; $display("FAIL busy_start_dones: got %0d want 1", dones); end
        n_checks++; if (first !== 6) begin n_fail++; $display("FAIL busy_start_latency: got %0d want 6", first); end
        for (int n = 0; n < 5; n++) begin
            n_checks++; if (res[n] !== 16'(exp_prod[n])) begin n_fail++; $display("FAIL busy_start_result%0d: got %0d want %0d", n, res[n], exp_prod[n]); end
        end
    endtask

    task automatic test_back_to_back();
        int d [4];
        int k = 0;
        load_prod();
        Start = 1'b1;
        @(posedge CLK); #1;
        for (int e = 1; e <= 30; e++) begin
            @(posedge CLK); #1;
            if (Done && k < 4) begin
                d[k] = e;
                k++;
            end
        end
        Start = 1'b0;
        repeat (8) @(posedge CLK);
        #1;
        n_checks++; if (k !== 4) begin n_fail++; $display("FAIL b2b_done_count: got %0d want 4", k); end
        if (k >= 3) begin
            n_checks++; if (d[0] !== 6) begin n_fail++; $display("FAIL b2b_first: got %0d want 6", d[0]); end
            n_checks++; if (d[1] - d[0] !== 7 || d[2] - d[1] !== 7) begin n_fail++; $display("FAIL b2b_period: got %0d,%0d want 7,7", d[1] - d[0], d[2] - d[1]); end
        end
        n_checks++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL b2b_idle: busy %b want 0", Busy); end
        for (int n = 0; n < 5; n++) begin
            n_checks++; if (res[n] !== 16'(exp_prod[n])) begin n_fail++; $display("FAIL b2b_result%0d: got %0d want %0d", n, res[n], exp_prod[n]); end
        end
    endtask

    task automatic test_reset_abort();
        int lat;
        load_prod();
        Start = 1'b1;
        @(posedge CLK); #1;
        Start = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        n_checks++; if (Busy !== 1'b0 || Rom_enable !== 1'b0) begin n_fail++; $display("FAIL abort_ctrl: busy %b rom_enable %b want 0 0", Busy, Rom_enable); end
        for (int n = 0; n < 5; n++) begin
            n_checks++; if (res[n] !== 16'sd0) begin n_fail++; $display("FAIL abort_result%0d: got %0d want 0", n, res[n]); end
        end
        repeat (3) @(posedge CLK);
        #1;
        n_checks++; if (Done !== 1'b0 || Busy !== 1'b0) begin n_fail++; $display("FAIL abort_stays_idle: done %b busy %b want 0 0", Done, Busy); end
        run_and_wait(lat);
        n_checks++; if (lat !== 6) begin n_fail++; $display("FAIL abort_rerun_latency: got %0d want 6", lat); end
        for (int n = 0; n < 5; n++) begin
            n_checks++; if (res[n] !== 16'(exp_prod[n])) begin n_fail++; $display("FAIL abort_rerun_result%0d: got %0d want %0d", n, res[n], exp_prod[n]); end
        end
    endtask

    task automatic test_tie();
        int lat;
        int exp_tie [5] = '{0, 100, 0, 0, 100};
        clear_image();
        set_row(0, 0, 100, 0, 0, 100);
        for (int i = 0; i < 4; i++) act[i] = 16'sd256;
        run_and_wait(lat);
        for (int n = 0; n < 5; n++) begin
            n_checks++; if (res[n] !== 16'(exp_tie[n])) begin n_fail++; $display("FAIL tie_result%0d: got %0d want %0d", n, res[n], exp_tie[n]); end
        end
`ifdef FC2_ARGMAX_EN
        n_checks++; if (Class_out !== 3'd1) begin n_fail++; $display("FAIL tie_class: got %0d want 1", Class_out); end
`endif
    endtask

    initial begin
        clear_image();
        test_reset();
        test_production();
        test_rom_bus();
        test_mixed_act();
        test_saturation();
        test_start_ignored();
        test_back_to_back();
        test_reset_abort();
        test_tie();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
